hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//   Drives the hold/clear inputs of the CPU pipeline stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Resolves memory-wait and multicycle-ALU stalls, load-use bubbles and branch/interrupt flushes.
//   Stores a redirect that arrives during a stall until the stall ends, and keeps stall statistics.
//   Holds a small FSM plus counters; hold/clear outputs are combinational from state and inputs.
// PARAMETERS
//   FLUSH_CYCLES  1     cycles IF/ID and ID/EX are cleared per redirect (>=1)
//   CNT_W         32    width of stall_cycles perf counter
//   MAX_WAIT      1023  consecutive mem_busy cycles before mem_timeout sets
// PORTS
//   clk           in   1      clock, all state on posedge
//   reset_n       in   1      asynchronous, active-low reset
//   mem_busy      in   1      MEM-stage bus access not yet complete
//   mc_busy       in   1      EX multicycle unit (mul/div) not done
//   load_use      in   1      DE instruction reads the register loaded by the EX instruction
//   redirect      in   1      1-cycle pulse: taken branch/jump/int/reti resolved in EX
//   pc_hold       out  1      hold PC
//   if_id_hold    out  1      |  if_id_clear   out 1
//   id_ex_hold    out  1      |  id_ex_clear   out 1
//   ex_mem_hold   out  1      |  ex_mem_clear  out 1
//   mem_wb_hold   out  1      |  mem_wb_clear  out 1
//   stall_cycles  out  CNT_W  cycles with pc_hold=1, saturating
//   mem_timeout   out  1      sticky: mem_busy lasted MAX_WAIT cycles
// BEHAVIOUR
//   Reset (reset_n=0): state RUN, pending=0, flush_cnt=0, counters 0, mem_timeout=0.
//     While reset_n=0: all *_clear=1, all *_hold=0, pc_hold=0.
//   Priority per cycle, highest first; signals not listed are 0:
//   1 mem_busy: pc/if_id/id_ex/ex_mem hold=1, mem_wb_clear=1.
//   2 mc_busy: pc/if_id/id_ex hold=1, ex_mem_clear=1.
//   3 flush (redirect, pending, or state FLUSH): if_id_clear=1, id_ex_clear=1.
//   4 load_use: pc_hold=1, if_id_hold=1, id_ex_clear=1.
//   5 otherwise all 0 (free-running).
//   Flush beats load_use: the DE instruction is wrong-path and is discarded.
//   Redirect during case 1/2: pending<=1; flush is applied on the first cycle
//     without mem_busy/mc_busy; pending clears that cycle.
//   FSM: RUN, STALL, FLUSH.
//     RUN->STALL on mem_busy|mc_busy. STALL->RUN when both are low and pending=0.
//     STALL->FLUSH when both are low and pending=1.
//     Applying a flush loads flush_cnt=FLUSH_CYCLES-1. Go to FLUSH if the result is nonzero, else RUN.
//     FLUSH: flush outputs each non-stalled cycle, flush_cnt decrements, at 0 -> RUN.
//     Stall in FLUSH -> STALL with flush_cnt frozen; on exit, resume FLUSH if flush_cnt>0.
//     New redirect in FLUSH reloads flush_cnt.
//   stall_cycles: +1 each cycle pc_hold=1. Saturates at all-ones, no wrap.
//   wait_cnt: consecutive mem_busy cycles, zeroed when mem_busy=0.
//     When it reaches MAX_WAIT, mem_timeout<=1 and stays 1 until reset.
//     wait_cnt saturates at MAX_WAIT.
//   Reset asserted mid-stall or mid-flush drops everything immediately (async). pending is lost.
//   No output ever has hold=1 and clear=1 simultaneously.
// TESTING
//   T1 reset_n=0 then release, inputs 0:
//      clears=1 during reset, then all outputs 0, stall_cycles=0.
//   T2 mem_busy=1 for 3 cycles:
//      pc/if_id/id_ex/ex_mem hold=1 and mem_wb_clear=1 for exactly 3 cycles, stall_cycles=3.
//   T3 load_use=1 for 1 cycle:
//      pc_hold=if_id_hold=id_ex_clear=1 for that cycle only.
//   T4 redirect and load_use in the same cycle:
//      if_id_clear=id_ex_clear=1, pc_hold=0.
//      FLUSH_CYCLES=2: clears repeat next cycle, then RUN.
//   T5 redirect while mc_busy=1 (busy 4 more cycles):
//      no clears during busy (ex_mem_clear=1).
//      Cycle after busy drops: if_id_clear=id_ex_clear=1.
//   T6 MAX_WAIT=8, mem_busy held 10 cycles:
//      mem_timeout rises after the 8th cycle and stays 1 after mem_busy drops, until reset_n=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Generates hold/clear controls for the pipeline stage registers
//            (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Handles memory-wait and
//            multicycle stalls, load-use bubbles and redirect flushes. A
//            redirect seen during a stall is parked until the stall ends.
//            Also provides a saturating stall counter and a sticky
//            memory-timeout flag.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32,
  parameter int MAX_WAIT     = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_busy,
  input  logic             mc_busy,
  input  logic             load_use,
  input  logic             redirect,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_clear,
  output logic             id_ex_hold,
  output logic             id_ex_clear,
  output logic             ex_mem_hold,
  output logic             ex_mem_clear,
  output logic             mem_wb_hold,
  output logic             mem_wb_clear,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  // flush_cnt only ever holds the remaining cycles after the first flush cycle
  localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [FC_W-1:0]   FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX     = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              pending, pending_n;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall_any;
  logic              flush_resume;
  logic              flush_now;

  assign stall_any = mem_busy | mc_busy;
  // A flush interrupted by a stall carries on the first cycle the stall lifts,
  // so the wrong-path instructions held in IF/ID and ID/EX are still discarded.
  assign flush_resume = (state == ST_STALL) && (flush_cnt != '0);
  assign flush_now    = !stall_any &&
                        (redirect || pending || (state == ST_FLUSH) || flush_resume);

  // State, pending redirect and remaining flush cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      pending   <= 1'b0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // Next-state logic and prioritised hold/clear outputs
  always_comb begin
    state_n      = state;
    pending_n    = pending;
    flush_cnt_n  = flush_cnt;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_clear  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_hold  = 1'b0;
    ex_mem_clear = 1'b0;
    mem_wb_hold  = 1'b0;
    mem_wb_clear = 1'b0;

    if (stall_any) begin
      state_n = ST_STALL;
      if (redirect) pending_n = 1'b1;
    end else if (redirect || pending) begin
      pending_n   = 1'b0;
      flush_cnt_n = FLUSH_RELOAD;
      state_n     = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
    end else if ((state == ST_FLUSH) || flush_resume) begin
      flush_cnt_n = (flush_cnt != '0) ? flush_cnt - 1'b1 : '0;
      state_n     = (flush_cnt_n != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      state_n = ST_RUN;
    end

    if (!reset_n) begin
      // Every stage register is emptied while reset is held
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_clear = 1'b1;
      mem_wb_clear = 1'b1;
    end else if (mem_busy) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_hold   = 1'b1;
      ex_mem_hold  = 1'b1;
      mem_wb_clear = 1'b1;
    end else if (mc_busy) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_hold   = 1'b1;
      ex_mem_clear = 1'b1;
    end else if (flush_now) begin
      // Flush wins over load_use: the dependent DE instruction is wrong-path
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
    end else if (load_use) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_clear  = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (pc_hold && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // Consecutive mem_busy watchdog with sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (!mem_busy) begin
      wait_cnt <= '0;
    end else begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WAIT_MAX - 1'b1) mem_timeout <= 1'b1;
    end
  end

endmodule
`default_nettype wire
